// File: rtl/m_seq_pkg.sv
// Shared constants, FSM state type and LFSR helpers for the M-sequence despreader.
// The code->phase relation is the same one the generator uses: code k is the LFSR phase k steps after 6'b101010.
package m_seq_pkg;
  localparam int N = 63;
  localparam int LENGTH = $clog2(N);
  localparam logic [LENGTH-1:0] POLYNOME = 6'b100111;
  localparam logic [LENGTH-1:0] CODE0_PHASE = 6'b101010;

  typedef logic [LENGTH-1:0] word_t;
  typedef enum logic [1:0] {IDLE, ACQ, TRACK, DONE} state_t;

  function automatic word_t lfsr_step(word_t s);
    return {^(POLYNOME & s), s[LENGTH-1:1]};
  endfunction

  function automatic word_t lfsr_adv(word_t s, int steps);
    word_t r;
    r = s;
    for (int k = 0; k < steps; k++) r = lfsr_step(r);
    return r;
  endfunction

  // Walks the maximal-length sequence; every nonzero phase matches exactly one code, zero matches none.
  function automatic word_t phase2code(word_t phase);
    word_t s;
    word_t code;
    s = CODE0_PHASE;
    code = '0;
    for (int k = 0; k < N; k++) begin
      if (s == phase) code = word_t'(k);
      s = lfsr_step(s);
    end
    return code;
  endfunction
endpackage

// File: rtl/m_sequence_despreader_if.sv
// Sample-in / verdict-out bundle of the despreader; the slave side is the despreader itself.
interface m_sequence_despreader_if;
  import m_seq_pkg::*;
  logic  sample_i;
  logic  sample_valid_i;
  logic  frame_start_i;
  word_t code_o;
  word_t err_cnt_o;
  logic  code_valid_o;
  logic  lock_o;
  logic  bad_phase_o;
  logic  busy_o;

  modport master (
    output sample_i, sample_valid_i, frame_start_i,
    input  code_o, err_cnt_o, code_valid_o, lock_o, bad_phase_o, busy_o
  );
  modport slave (
    input  sample_i, sample_valid_i, frame_start_i,
    output code_o, err_cnt_o, code_valid_o, lock_o, bad_phase_o, busy_o
  );
endinterface

// File: rtl/m_seq_chip_sampler.sv
// Groups HOLD valid samples into one chip decision (chip_stb on the last sample of the chip).
// MSEQ_MAJORITY_VOTE_EN selects a majority vote; otherwise the centre sample HOLD/2 is taken.
module m_seq_chip_sampler #(
  parameter int HOLD = 3
) (
  input  logic clkin,
  input  logic rstn,
  input  logic sample,
  input  logic sample_valid,
  input  logic frame_start,
  output logic chip,
  output logic chip_stb
);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int CENTRE = HOLD / 2;

  logic [CW-1:0] samp_cnt;
  logic [CW-1:0] idx;

  // A frame start always realigns the chip grid: that sample is sample 0.
  assign idx      = frame_start ? '0 : samp_cnt;
  assign chip_stb = sample_valid && (idx == CW'(HOLD - 1));

  always_ff @(posedge clkin) begin
    // NOTE: sequential state is updated with non-blocking assignments so all registers see pre-edge values.
    if (!rstn)             samp_cnt <= '0;
    else if (sample_valid) samp_cnt <= chip_stb ? '0 : idx + 1'b1;
  end

`ifdef MSEQ_MAJORITY_VOTE_EN
  logic [CW:0] ones_q;
  logic [CW:0] ones;

  assign ones = ((idx == '0) ? '0 : ones_q) + (CW+1)'(sample);
  assign chip = ({ones, 1'b0} >= (CW+2)'(HOLD));

  always_ff @(posedge clkin) begin
    if (!rstn)             ones_q <= '0;
    else if (sample_valid) ones_q <= ones;
  end
`else
  logic centre_q;

  assign chip = (idx == CW'(CENTRE)) ? sample : centre_q;

  always_ff @(posedge clkin) begin
    if (!rstn)                                        centre_q <= 1'b0;
    else if (sample_valid && (idx == CW'(CENTRE)))    centre_q <= sample;
  end
`endif
endmodule

// File: rtl/m_sequence_despreader.sv
// Recovers the shift code from the first LENGTH chips of a frame and counts mismatches of the rest
// against a local LFSR replica. Chip decision mode is chosen by MSEQ_MAJORITY_VOTE_EN (see sampler).
module m_sequence_despreader
  import m_seq_pkg::*;
#(
  parameter int HOLD    = 3,
  parameter int ERR_MAX = 4
) (
  input logic                     clkin,
  input logic                     rstn,
  m_sequence_despreader_if.slave  bus
);
  state_t state, state_nxt;
  word_t  chip_idx, phase_acq, lfsr, err_cnt;
  word_t  phase_nxt;
  logic   chip, chip_stb, start;

  assign start     = bus.sample_valid_i && bus.frame_start_i;
  assign phase_nxt = {chip, phase_acq[LENGTH-1:1]};

  m_seq_chip_sampler #(.HOLD(HOLD)) u_sampler (
    .clkin        (clkin),
    .rstn         (rstn),
    .sample       (bus.sample_i),
    .sample_valid (bus.sample_valid_i),
    .frame_start  (bus.frame_start_i),
    .chip         (chip),
    .chip_stb     (chip_stb)
  );

  always_ff @(posedge clkin) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = ACQ;
      ACQ: begin
        if (start) state_nxt = ACQ;
        else if (chip_stb && chip_idx == word_t'(N - 1)) state_nxt = DONE;
        else if (chip_stb && chip_idx == word_t'(LENGTH - 1)) state_nxt = TRACK;
      end
      TRACK: begin
        if (start) state_nxt = ACQ;
        else if (chip_stb && chip_idx == word_t'(N - 1)) state_nxt = DONE;
      end
      DONE:  state_nxt = start ? ACQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath; a frame start in any state restarts acquisition at chip 0.
  always_ff @(posedge clkin) begin
    if (!rstn) begin
      chip_idx  <= '0;
      phase_acq <= '0;
      lfsr      <= '0;
      err_cnt   <= '0;
    end else if (start) begin
      err_cnt  <= '0;
      chip_idx <= chip_stb ? word_t'(1) : '0;
      if (chip_stb) phase_acq <= phase_nxt;
    end else if (chip_stb) begin
      case (state)
        ACQ: begin
          phase_acq <= phase_nxt;
          chip_idx  <= chip_idx + 1'b1;
          // Replica must predict chip LENGTH next, i.e. be LENGTH steps past the start phase.
          if (chip_idx == word_t'(LENGTH - 1)) lfsr <= lfsr_adv(phase_nxt, LENGTH);
        end
        TRACK: begin
          if (chip != lfsr[0] && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          lfsr     <= lfsr_step(lfsr);
          chip_idx <= chip_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clkin) begin
    if (!rstn) begin
      bus.code_valid_o <= 1'b0;
      bus.code_o       <= '0;
      bus.err_cnt_o    <= '0;
      bus.lock_o       <= 1'b0;
      bus.bad_phase_o  <= 1'b0;
    end else begin
      bus.code_valid_o <= (state == DONE);
      if (state == DONE) begin
        bus.code_o      <= phase2code(phase_acq);
        bus.err_cnt_o   <= err_cnt;
        bus.bad_phase_o <= (phase_acq == '0);
        bus.lock_o      <= (phase_acq != '0) && (err_cnt <= word_t'(ERR_MAX));
      end
    end
  end

  assign bus.busy_o = (state != IDLE);
endmodule

// File: tb/tb_m_sequence_despreader.sv
// Self-checking bench: frames built from the m-sequence as a cyclic bit pattern, verdicts predicted
// by matching the first six chips and counting chip differences; one compare process per cycle.
module tb_m_sequence_despreader;
  localparam int HOLD = 3;

  typedef struct packed {
    logic [5:0] code;
    logic [5:0] err;
    logic       lock;
    logic       bad;
  } res_t;

  typedef struct {
    res_t r;
    int   due;
  } exp_t;

  logic clkin = 1'b0;
  logic rstn  = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit [62:0] mseq;
  exp_t exp_q[$];
  res_t held = '0;

  m_sequence_despreader_if bus();

  m_sequence_despreader #(.HOLD(HOLD), .ERR_MAX(4)) dut (
    .clkin (clkin),
    .rstn  (rstn),
    .bus   (bus.slave)
  );

  always #5 clkin = ~clkin;
  always @(posedge clkin) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // One period of the m-sequence: chip j is the LSB of the generator state j steps after 6'b101010.
  function automatic bit [62:0] build_mseq();
    bit [5:0]  st;
    bit [62:0] r;
    st = 6'b101010;
    for (int j = 0; j < 63; j++) begin
      r[j] = st[0];
      st = {^(st & 6'b100111), st[5:1]};
    end
    return r;
  endfunction

  // Frame chips of code c: the m-sequence read cyclically from offset c.
  function automatic bit [62:0] gen(int c);
    bit [62:0] r;
    for (int i = 0; i < 63; i++) r[i] = mseq[(c + i) % 63];
    return r;
  endfunction

  function automatic res_t model(bit [62:0] ch);
    res_t      r;
    bit [62:0] rf;
    bit [62:0] cand;
    int        errs;
    rf = '0;
    r.code = '0;
    r.bad = (ch[5:0] == 6'd0);
    if (!r.bad)
      for (int c = 0; c < 63; c++) begin
        cand = gen(c);
        if (cand[5:0] == ch[5:0]) begin
          r.code = 6'(c);
          rf = cand;
        end
      end
    errs  = $countones((ch ^ rf) & ~63'h3F);
    r.err = (errs > 63) ? 6'd63 : 6'(errs);
    r.lock = !r.bad && (errs <= 4);
    return r;
  endfunction

  task automatic drive(bit v, bit s, bit fs);
    @(posedge clkin);
    #1;
    bus.sample_valid_i = v;
    bus.sample_i       = s;
    bus.frame_start_i  = fs;
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0);
  endtask

  // Sends chips 0..stop-1; only a complete frame (stop == 63) produces an expected verdict.
  task automatic send_frame(bit [62:0] ch, int gap_pct, int stop, bit noise);
    exp_t e;
    for (int i = 0; i < stop; i++) begin
      for (int j = 0; j < HOLD; j++) begin
        while (int'($urandom_range(99)) < gap_pct) drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, ch[i] ^ (noise && j == 0 && $urandom_range(1) == 1), i == 0 && j == 0);
      end
      if (i == 20) begin
        @(negedge clkin);
        check("busy_mid_frame", 32'(bus.busy_o), 32'd1);
      end
    end
    if (stop == 63) begin
      e.r   = model(ch);
      e.due = cyc + 2;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clkin) begin
    res_t act;
    bit   want;
    act = {bus.code_o, bus.err_cnt_o, bus.lock_o, bus.bad_phase_o};
    if (!rstn) begin
      held = '0;
      exp_q.delete();
    end else begin
      want = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      check("code_valid", 32'(bus.code_valid_o), 32'(want));
      if (want) begin
        check("verdict", 32'(act), 32'(exp_q[0].r));
        held = exp_q[0].r;
        void'(exp_q.pop_front());
      end else begin
        check("hold", 32'(act), 32'(held));
      end
    end
  end

  initial begin
    bit [62:0] ch;
    bit [62:0] flips;
    res_t      m;

    bus.sample_i       = 1'b0;
    bus.sample_valid_i = 1'b0;
    bus.frame_start_i  = 1'b0;
    mseq = build_mseq();

    // Hand-derived anchors for the model.
    check("pin_mseq_start", 32'(mseq[5:0]), 32'h2A);
    ch = gen(5);
    check("pin_code5_chips", 32'(ch[5:0]), 32'h19);
    m = model(gen(5));
    check("pin_model_t1", 32'(m), 32'({6'd5, 6'd0, 1'b1, 1'b0}));
    m = model(gen(20) ^ ((63'd1 << 10) | (63'd1 << 30) | (63'd1 << 50)));
    check("pin_model_3flips", 32'(m), 32'({6'd20, 6'd3, 1'b1, 1'b0}));
    m = model(gen(20) ^ ((63'd1 << 10) | (63'd1 << 20) | (63'd1 << 30) | (63'd1 << 40) | (63'd1 << 50)));
    check("pin_model_5flips", 32'(m), 32'({6'd20, 6'd5, 1'b0, 1'b0}));
    m = model(gen(7) & ~63'h3F);
    check("pin_model_badphase", 32'({m.code, m.lock, m.bad}), 32'({6'd0, 1'b0, 1'b1}));

    repeat (3) @(posedge clkin);
    #1 rstn = 1'b1;
    @(negedge clkin);
    check("reset_busy", 32'(bus.busy_o), 32'd0);
    check("reset_outputs", 32'({bus.code_o, bus.err_cnt_o, bus.lock_o, bus.bad_phase_o, bus.code_valid_o}), 32'd0);

    // Clean code 5, then flipped-chip frames on code 20.
    send_frame(gen(5), 0, 63, 1'b0);
    idle(4);
    send_frame(gen(20) ^ ((63'd1 << 10) | (63'd1 << 30) | (63'd1 << 50)), 0, 63, 1'b0);
    idle(3);
    send_frame(gen(20) ^ ((63'd1 << 10) | (63'd1 << 20) | (63'd1 << 30) | (63'd1 << 40) | (63'd1 << 50)), 0, 63, 1'b0);
    idle(3);

    // Every code back-to-back, with a disagreeing minority sample now and then.
    for (int c = 0; c < 63; c++) send_frame(gen(c), 0, 63, 1'b1);
    idle(4);

    // Code 41 without and with 50% valid gaps.
    send_frame(gen(41), 0, 63, 1'b0);
    idle(2);
    send_frame(gen(41), 50, 63, 1'b0);
    idle(5);

    // Frame abandoned at chip 30 by a new frame start, then clean code 7.
    send_frame(gen(33), 0, 30, 1'b0);
    send_frame(gen(7), 0, 63, 1'b0);
    idle(3);

    // Random codes, chip flips, gaps and sample noise.
    for (int f = 0; f < 12; f++) begin
      flips = '0;
      for (int i = 0; i < 63; i++) flips[i] = ($urandom_range(24) == 0);
      send_frame(gen(int'($urandom_range(62))) ^ flips, int'($urandom_range(40)), 63, 1'b1);
      idle(int'($urandom_range(3)));
    end
    idle(4);

    // Illegal all-zero phase, then a frame cut by reset at chip 40.
    send_frame(gen(7) & ~63'h3F, 0, 63, 1'b0);
    idle(4);
    send_frame(gen(12), 0, 40, 1'b0);
    @(posedge clkin);
    #1;
    rstn = 1'b0;
    bus.sample_valid_i = 1'b0;
    bus.frame_start_i  = 1'b0;
    @(posedge clkin);
    #1 rstn = 1'b1;
    @(negedge clkin);
    check("rst_mid_busy", 32'(bus.busy_o), 32'd0);
    check("rst_mid_outputs", 32'({bus.code_o, bus.err_cnt_o, bus.lock_o, bus.bad_phase_o, bus.code_valid_o}), 32'd0);
    idle(250);

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge clkin);
    check("pending_verdicts", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
